run_length_detector: RTL and testbench
======================================

Name: run_length_detector

Overview:
Parametrised successor to the team's "more than one 1" serial FSM. Watches a strobed serial bit stream and flags runs of at least MIN_RUN consecutive bits equal to a selectable target value. Supports one-shot or retriggering detection, a saturating run-length readout and a clearable saturating detection counter. Sits behind a serial receiver or debouncer as a pattern/activity monitor.

Parameters:
MIN_RUN, 2, consecutive matching bits needed for a detection; legal range is 1 to 2**RUN_W-1.
RUN_W, 4, width of the run-length counter and of the run_len output.
CNT_W, 8, width of the detection event counter.

Ports:
clk  input  1  single clock; all logic on rising edge.
rst  input  1  reset; synchronous, active-low (0 = reset).
en  input  1  sample strobe; din/target/retrig are used only on edges where en=1.
din  input  1  serial data bit.
target  input  1  bit value being counted (1 = runs of ones, 0 = runs of zeros).
retrig  input  1  0 = one det per run; 1 = det every MIN_RUN matching bits, non-overlapping.
cnt_clr  input  1  synchronous clear of det_count (and max_run when the optional feature is built in).
det  output  1  registered single-cycle detection pulse.
active  output  1  registered level; high while the current run length is >= MIN_RUN.
run_len  output  RUN_W  current run length, saturating at 2**RUN_W-1.
det_count  output  CNT_W  number of det pulses, saturating at 2**CNT_W-1.
max_run  output  RUN_W  longest run seen (optional feature; tied to 0 when not built in).

Behaviour:
- Reset: on an edge with rst=0, the FSM goes to IDLE and det=0, active=0, run_len=0, det_count=0, max_run=0. Reset overrides every other input, including in the middle of a run.
- en=0: all state and outputs hold, except det, which is forced to 0 on that edge. det is never high for more than one cycle.
- Match definition: a sample matches when din==target, evaluated with the target value present on that same edge. A change of target mid-run is just a mismatch/match per bit and gets no special handling.
- Internal seg_cnt (RUN_W bits) counts matches since the last detection or mismatch.
- FSM states:
  - IDLE (run_len=0): a match moves to COUNT with seg_cnt=1 and run_len=1. If MIN_RUN=1, that same sample is handled as reaching the threshold (see COUNT).
  - COUNT: a match increments seg_cnt and run_len. When seg_cnt reaches MIN_RUN, det=1 on that edge, active=1, and the FSM moves to HIT.
    - retrig=1 at that edge: seg_cnt resets to 0.
    - retrig=0 at that edge: seg_cnt holds.
  - HIT:
    - A match increments run_len.
    - If retrig=1, seg_cnt also increments, and reaching MIN_RUN pulses det again and resets seg_cnt to 0.
    - If retrig=0, no further det for this run.
  - Any state: a mismatch returns the FSM to IDLE with run_len=0, seg_cnt=0, active=0 on that edge. No det is produced on a mismatch.
- Latency: det, active and run_len reflect the sample taken on edge N, valid from edge N until edge N+1.
- run_len saturates at 2**RUN_W-1 and holds there while matches continue; no wrap.
- det_count:
  - Increments on every det; saturates at 2**CNT_W-1.
  - cnt_clr=1 alone sets it to 0.
  - cnt_clr=1 together with det on the same edge sets it to 1, so the event is not lost.
  - cnt_clr acts regardless of en.

Optional Feature:
Macro RLD_MAX_RUN_EN.
- Defined: max_run is a register updated on each en edge to max(max_run, new run_len), so it saturates with run_len. It is cleared by reset. cnt_clr loads it with the current new run_len (0 if the sample mismatches).
- Not defined: max_run is constant 0 and no register is inferred. The port list is identical in both builds.

Test Plan:
1. Defaults, target=1, retrig=0, en=1, din sequence 0,0,1,0,1,0,0,1,1,0,1,1,1,0,0,1,1 -> det after samples 9, 12 and 17 only; det_count=3; active high after samples 9, 12, 13 and 17; run_len=3 after sample 13.
2. Five consecutive ones, target=1 -> retrig=0 gives det after sample 2 only and count 1; retrig=1 gives det after samples 2 and 4 and count 2.
3. RUN_W=4, MIN_RUN=2, 20 consecutive ones -> run_len climbs to 15 and holds; one det; a 0 then drops run_len to 0 and active to 0.
4. CNT_W=2, five separate 2-bit runs -> det_count reads 1, 2, 3, 3, 3; cnt_clr on the same edge as the fifth det -> det_count=1.
5. target=0, en toggling 1/0 each cycle with din=0 -> count advances only on en=1 edges; det high one cycle and 0 while en=0; run_len held across en=0.
6. rst=0 asserted after 3 matching bits, then released -> all outputs 0 on the next edge; a new detection needs a fresh MIN_RUN matches. With RLD_MAX_RUN_EN, max_run=3 before the reset and 0 after it.

Source files
------------

// File: rtl/run_length_detector.sv
// run_length_detector: flags runs of >= MIN_RUN bits equal to target; define RLD_MAX_RUN_EN to build the max_run tracker
module run_length_detector #(
    parameter int MIN_RUN = 2,
    parameter int RUN_W   = 4,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             din,
    input  logic             target,
    input  logic             retrig,
    input  logic             cnt_clr,
    output logic             det,
    output logic             active,
    output logic [RUN_W-1:0] run_len,
    output logic [CNT_W-1:0] det_count,
    output logic [RUN_W-1:0] max_run
);
    typedef enum logic [1:0] {IDLE, COUNT, HIT} state_t;

    localparam logic [RUN_W-1:0] MIN     = RUN_W'(MIN_RUN);
    localparam logic [RUN_W-1:0] RUN_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state, state_n;
    logic [RUN_W-1:0] seg_cnt, seg_n, seg_inc, run_n;
    logic             det_n, active_n, match;

    assign match   = din == target;
    assign seg_inc = seg_cnt + RUN_W'(1);

    // next state, segment/run counters and detection for the current sample
    always_comb begin
        state_n  = state;
        seg_n    = seg_cnt;
        run_n    = run_len;
        active_n = active;
        det_n    = 1'b0;
        if (en) begin
            if (!match) begin
                state_n  = IDLE;
                seg_n    = '0;
                run_n    = '0;
                active_n = 1'b0;
            end else begin
                run_n = (run_len == RUN_MAX) ? run_len : run_len + RUN_W'(1);
                if (state == HIT) begin
                    active_n = 1'b1;
                    if (retrig) begin
                        det_n = seg_inc == MIN;
                        seg_n = det_n ? '0 : seg_inc;
                    end
                end else if (seg_inc == MIN) begin
                    det_n    = 1'b1;
                    active_n = 1'b1;
                    state_n  = HIT;
                    seg_n    = retrig ? '0 : seg_inc;
                end else begin
                    state_n = COUNT;
                    seg_n   = seg_inc;
                end
            end
        end
    end

    // state and output registers; det only lives for the edge that produced it
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            seg_cnt <= '0;
            run_len <= '0;
            active  <= 1'b0;
            det     <= 1'b0;
        end else begin
            state   <= state_n;
            seg_cnt <= seg_n;
            run_len <= run_n;
            active  <= active_n;
            det     <= det_n;
        end
    end

    // saturating detection counter; a clear coinciding with a detection keeps that event
    always_ff @(posedge clk) begin
        if (!rst)
            det_count <= '0;
        else if (cnt_clr)
            det_count <= CNT_W'(det_n);
        else if (det_n && det_count != CNT_MAX)
            det_count <= det_count + CNT_W'(1);
    end

`ifdef RLD_MAX_RUN_EN
    // longest run seen; follows the saturating run length, clear reloads the new run length
    always_ff @(posedge clk) begin
        if (!rst)
            max_run <= '0;
        else if (cnt_clr)
            max_run <= run_n;
        else if (run_n > max_run)
            max_run <= run_n;
    end
`else
    assign max_run = '0;
`endif
endmodule

// File: tb/tb_run_length_detector.sv
// tb_run_length_detector: directed scoreboard bench for run_length_detector (MIN_RUN=2, RUN_W=4, CNT_W=2)
module tb_run_length_detector;
    logic       clk = 1'b0, rst = 1'b0, en = 1'b0, din = 1'b0, target = 1'b0, retrig = 1'b0, cnt_clr = 1'b0;
    logic       det, active;
    logic [3:0] run_len, max_run;
    logic [1:0] det_count;

    typedef struct {
        logic       det;
        logic       act;
        logic [3:0] run;
        logic [1:0] cnt;
        logic [3:0] mx;
        string      tag;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0, n_bad = 0;
    logic cur_rst = 1'b1, cur_en = 1'b1, cur_t = 1'b1, cur_rt = 1'b0, cur_clr = 1'b0;

    run_length_detector #(.MIN_RUN(2), .RUN_W(4), .CNT_W(2)) dut (
        .clk(clk), .rst(rst), .en(en), .din(din), .target(target), .retrig(retrig),
        .cnt_clr(cnt_clr), .det(det), .active(active), .run_len(run_len),
        .det_count(det_count), .max_run(max_run)
    );

    always #5 clk = ~clk;

    // drive one sample at the falling edge and queue what the next rising edge must produce
    task automatic s(input logic d, input logic ed, input logic ea, input int er, input int ec, input int em, input string tag);
        exp_t e;
        @(negedge clk);
        rst = cur_rst; en = cur_en; din = d; target = cur_t; retrig = cur_rt; cnt_clr = cur_clr;
        e.det = ed; e.act = ea; e.run = 4'(er); e.cnt = 2'(ec);
`ifdef RLD_MAX_RUN_EN
        e.mx = 4'(em);
`else
        e.mx = 4'(em & 0);
`endif
        e.tag = tag;
        q.push_back(e);
    endtask

    task automatic rs(input string tag);
        cur_rst = 1'b0;
        s(1'b1, 0, 0, 0, 0, 0, tag);
        cur_rst = 1'b1;
    endtask

    // monitor: every rising edge is an output cycle, compare once outputs settle
    always @(posedge clk) begin
        #1;
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            n_cmp++;
            if ({det, active, run_len, det_count, max_run} !== {e.det, e.act, e.run, e.cnt, e.mx}) begin
                n_bad++;
                $display("FAIL %s: det/act/run/cnt/max got %b/%b/%0d/%0d/%0d required %b/%b/%0d/%0d/%0d",
                         e.tag, det, active, run_len, det_count, max_run, e.det, e.act, e.run, e.cnt, e.mx);
            end
        end
    end

    initial begin
        rs("reset0");
        rs("reset1");
        // 1: defaults, target=1, retrig=0
        s(0,0,0,0,0,0,"t1_1");  s(0,0,0,0,0,0,"t1_2");  s(1,0,0,1,0,1,"t1_3");  s(0,0,0,0,0,1,"t1_4");
        s(1,0,0,1,0,1,"t1_5");  s(0,0,0,0,0,1,"t1_6");  s(0,0,0,0,0,1,"t1_7");  s(1,0,0,1,0,1,"t1_8");
        s(1,1,1,2,1,2,"t1_9");  s(0,0,0,0,1,2,"t1_10"); s(1,0,0,1,1,2,"t1_11"); s(1,1,1,2,2,2,"t1_12");
        s(1,0,1,3,2,3,"t1_13"); s(0,0,0,0,2,3,"t1_14"); s(0,0,0,0,2,3,"t1_15"); s(1,0,0,1,2,3,"t1_16");
        s(1,1,1,2,3,3,"t1_17");
        // 2a: five ones, one-shot
        rs("t2_rst_a");
        s(1,0,0,1,0,1,"t2a_1"); s(1,1,1,2,1,2,"t2a_2"); s(1,0,1,3,1,3,"t2a_3");
        s(1,0,1,4,1,4,"t2a_4"); s(1,0,1,5,1,5,"t2a_5"); s(0,0,0,0,1,5,"t2a_end");
        // 2b: five ones, retriggering
        rs("t2_rst_b");
        cur_rt = 1'b1;
        s(1,0,0,1,0,1,"t2b_1"); s(1,1,1,2,1,2,"t2b_2"); s(1,0,1,3,1,3,"t2b_3");
        s(1,1,1,4,2,4,"t2b_4"); s(1,0,1,5,2,5,"t2b_5"); s(0,0,0,0,2,5,"t2b_end");
        cur_rt = 1'b0;
        // 3: run length saturation
        rs("t3_rst");
        for (int i = 1; i <= 20; i++)
            s(1, i == 2, i >= 2, (i > 15) ? 15 : i, (i >= 2) ? 1 : 0, (i > 15) ? 15 : i, $sformatf("t3_%0d", i));
        s(0,0,0,0,1,15,"t3_drop");
        // 4: detection counter saturation and clear
        rs("t4_rst");
        for (int k = 0; k < 5; k++) begin
            s(1, 0, 0, 1, (k > 3) ? 3 : k, (k == 0) ? 1 : 2, $sformatf("t4_r%0d_a", k));
            s(1, 1, 1, 2, (k + 1 > 3) ? 3 : k + 1, 2, $sformatf("t4_r%0d_b", k));
            s(0, 0, 0, 0, (k + 1 > 3) ? 3 : k + 1, 2, $sformatf("t4_r%0d_c", k));
        end
        s(1,0,0,1,3,2,"t4_clr_a");
        cur_clr = 1'b1;
        s(1,1,1,2,1,2,"t4_clr_det");
        cur_clr = 1'b0;
        s(0,0,0,0,1,2,"t4_clr_b");
        cur_clr = 1'b1; cur_en = 1'b0;
        s(1,0,0,0,0,0,"t4_clr_noen");
        cur_clr = 1'b0; cur_en = 1'b1;
        // 5: target=0 with en toggling; mismatches while en=0 are ignored
        rs("t5_rst");
        cur_t = 1'b0;
        s(0,0,0,1,0,1,"t5_e1a");
        cur_en = 1'b0; s(1,0,0,1,0,1,"t5_e0a");
        cur_en = 1'b1; s(0,1,1,2,1,2,"t5_e1b");
        cur_en = 1'b0; s(1,0,1,2,1,2,"t5_e0b");
        cur_en = 1'b1; s(0,0,1,3,1,3,"t5_e1c");
        cur_en = 1'b0; s(1,0,1,3,1,3,"t5_e0c");
        cur_en = 1'b1; s(1,0,0,0,1,3,"t5_miss");
        cur_t = 1'b1;
        // 6: reset mid-run
        rs("t6_rst");
        s(1,0,0,1,0,1,"t6_1"); s(1,1,1,2,1,2,"t6_2"); s(1,0,1,3,1,3,"t6_3");
        rs("t6_midrst");
        s(1,0,0,1,0,1,"t6_4"); s(1,1,1,2,1,2,"t6_5");
        for (int i = 0; i < 10 && q.size() != 0; i++)
            @(posedge clk);
        #2;
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: pending %0d required 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
